// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the multicycle Harvard core and its bus bridge.
package mips_cpu_pkg;

   typedef enum logic [2:0] {
      CHECK  = 3'd0,
      IFETCH = 3'd1,
      DATA   = 3'd2,
      STEP   = 3'd3,
      HALT   = 3'd4
   } bridge_state_t;

   localparam logic [3:0] BUS_BE_WORD = 4'hF;

endpackage

// File: rtl/mips_cpu_harvard_bus_bridge.sv
// Serialises the core's instruction and data ports onto one wait-stated bus
// and strobes the core's clock enable once both read buffers are settled.
module mips_cpu_harvard_bus_bridge
   import mips_cpu_pkg::*;
#(
   parameter bit SKIP_REFETCH = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_active,
   output logic        cpu_clk_enable,
   input  logic [31:0] instr_address,
   output logic [31:0] instr_readdata,
   input  logic [31:0] data_address,
   input  logic        data_read,
   input  logic        data_write,
   input  logic [31:0] data_writedata,
   output logic [31:0] data_readdata,
   output logic [31:0] bus_address,
   output logic        bus_read,
   output logic        bus_write,
   output logic [3:0]  bus_byteenable,
   output logic [31:0] bus_writedata,
   input  logic        bus_waitrequest,
   input  logic [31:0] bus_readdata
);

   bridge_state_t state;
   logic [29:0]   itag;
   logic          ivalid;
   logic          hit;
   logic          data_req;
   logic [31:0]   data_word_addr;
   logic          unused_lsbs;

   assign hit            = SKIP_REFETCH && ivalid &&
                           (itag == instr_address[31:2]);
   assign data_req       = data_read | data_write;
   assign data_word_addr = {data_address[31:2], 2'b00};
   assign unused_lsbs    = ^{instr_address[1:0], data_address[1:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= CHECK;
         itag           <= '0;
         ivalid         <= 1'b0;
         cpu_clk_enable <= 1'b0;
         instr_readdata <= '0;
         data_readdata  <= '0;
         bus_address    <= '0;
         bus_read       <= 1'b0;
         bus_write      <= 1'b0;
         bus_byteenable <= 4'h0;
         bus_writedata  <= '0;
      end else begin
         cpu_clk_enable <= 1'b0;
         unique case (state)
            CHECK: begin
               if (!cpu_active) begin
                  state <= HALT;
               end else if (!hit) begin
                  state          <= IFETCH;
                  bus_address    <= {instr_address[31:2], 2'b00};
                  bus_read       <= 1'b1;
                  bus_byteenable <= BUS_BE_WORD;
               end else if (data_req) begin
                  state          <= DATA;
                  bus_address    <= data_word_addr;
                  bus_write      <= data_write;
                  bus_read       <= data_read & ~data_write;
                  bus_writedata  <= data_writedata;
                  bus_byteenable <= BUS_BE_WORD;
               end else begin
                  state          <= STEP;
                  cpu_clk_enable <= 1'b1;
               end
            end
            IFETCH: begin
               if (!bus_waitrequest) begin
                  instr_readdata <= bus_readdata;
                  itag           <= instr_address[31:2];
                  ivalid         <= 1'b1;
                  if (data_req) begin
                     state         <= DATA;
                     bus_address   <= data_word_addr;
                     bus_write     <= data_write;
                     bus_read      <= data_read & ~data_write;
                     bus_writedata <= data_writedata;
                  end else begin
                     state          <= STEP;
                     cpu_clk_enable <= 1'b1;
                     bus_read       <= 1'b0;
                     bus_byteenable <= 4'h0;
                  end
               end
            end
            DATA: begin
               if (!bus_waitrequest) begin
                  // A store into the buffered word must force a refetch.
                  if (bus_write && (bus_address[31:2] == itag))
                     ivalid <= 1'b0;
                  if (bus_read)
                     data_readdata <= bus_readdata;
                  state          <= STEP;
                  cpu_clk_enable <= 1'b1;
                  bus_read       <= 1'b0;
                  bus_write      <= 1'b0;
                  bus_byteenable <= 4'h0;
               end
            end
            STEP: state <= CHECK;
            HALT: state <= HALT;
            default: state <= CHECK;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_cpu_harvard_bus_bridge.sv
// Scoreboard bench: a wait-stated memory model answers the bus, expected
// core steps and bus transfers are queued as stimulus is driven.
module tb_mips_cpu_harvard_bus_bridge;

   typedef struct {
      logic [31:0] i;
      logic [31:0] d;
      int          lat;
   } step_t;

   typedef struct {
      logic [31:0] a;
      logic [1:0]  rw;
      logic [31:0] wd;
   } bop_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_active;
   logic        cpu_clk_enable;
   logic [31:0] instr_address;
   logic [31:0] instr_readdata;
   logic [31:0] data_address;
   logic        data_read;
   logic        data_write;
   logic [31:0] data_writedata;
   logic [31:0] data_readdata;
   logic [31:0] bus_address;
   logic        bus_read;
   logic        bus_write;
   logic [3:0]  bus_byteenable;
   logic [31:0] bus_writedata;
   logic        bus_waitrequest = 1'b0;
   logic [31:0] bus_readdata = 32'h0;

   logic        nr_clk_enable;
   logic [31:0] nr_instr;
   logic [31:0] nr_data;
   logic [31:0] nr_addr;
   logic        nr_read;
   logic        nr_write;
   logic [3:0]  nr_be;
   logic [31:0] nr_wdata;

   int checks = 0;
   int errors = 0;
   int ncyc = 0;
   int last_pulse = 0;
   int last_nr = 0;
   int ws_cfg = 0;
   int wcnt = 0;
   int act = 0;
   logic        stalled = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   logic [1:0]  prev_rw = 2'b00;

   logic [31:0] mem [logic [29:0]];
   step_t step_q[$];
   bop_t  bus_q[$];

   always #5 clk = ~clk;

   mips_cpu_harvard_bus_bridge #(.SKIP_REFETCH(1'b1)) dut (
      .clk(clk), .reset(reset), .cpu_active(cpu_active),
      .cpu_clk_enable(cpu_clk_enable),
      .instr_address(instr_address), .instr_readdata(instr_readdata),
      .data_address(data_address), .data_read(data_read),
      .data_write(data_write), .data_writedata(data_writedata),
      .data_readdata(data_readdata), .bus_address(bus_address),
      .bus_read(bus_read), .bus_write(bus_write),
      .bus_byteenable(bus_byteenable), .bus_writedata(bus_writedata),
      .bus_waitrequest(bus_waitrequest), .bus_readdata(bus_readdata)
   );

   mips_cpu_harvard_bus_bridge #(.SKIP_REFETCH(1'b0)) dut_nr (
      .clk(clk), .reset(reset), .cpu_active(cpu_active),
      .cpu_clk_enable(nr_clk_enable),
      .instr_address(instr_address), .instr_readdata(nr_instr),
      .data_address(32'h0), .data_read(1'b0),
      .data_write(1'b0), .data_writedata(32'h0),
      .data_readdata(nr_data), .bus_address(nr_addr),
      .bus_read(nr_read), .bus_write(nr_write),
      .bus_byteenable(nr_be), .bus_writedata(nr_wdata),
      .bus_waitrequest(1'b0), .bus_readdata(32'h24020005)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a[31:2])) return mem[a[31:2]];
      return 32'h0;
   endfunction

   // Memory model and monitor, sampling away from the active edge.
   always @(negedge clk) begin
      bop_t  b;
      step_t s;
      ncyc++;
      if (bus_read | bus_write) begin
         bus_waitrequest = (wcnt < ws_cfg);
         wcnt = bus_waitrequest ? wcnt + 1 : 0;
         bus_readdata = bus_read ? mem_rd(bus_address) : 32'h0;
         check("bus_be", {28'h0, bus_byteenable}, 32'hF);
         if (stalled) begin
            check("stall_addr", bus_address, prev_addr);
            check("stall_rw", {30'h0, bus_read, bus_write}, {30'h0, prev_rw});
         end
         if (!bus_waitrequest) begin
            check("bus_pending", {31'h0, bus_q.size() != 0}, 32'h1);
            if (bus_q.size() != 0) begin
               b = bus_q.pop_front();
               check("bus_addr", bus_address, b.a);
               check("bus_rw", {30'h0, bus_read, bus_write}, {30'h0, b.rw});
               if (bus_write) begin
                  check("bus_wdata", bus_writedata, b.wd);
                  mem[bus_address[31:2]] = bus_writedata;
               end
            end
         end
         stalled   = bus_waitrequest;
         prev_addr = bus_address;
         prev_rw   = {bus_read, bus_write};
      end else begin
         bus_waitrequest = 1'b0;
         bus_readdata    = 32'h0;
         wcnt            = 0;
         stalled         = 1'b0;
         check("bus_be_idle", {28'h0, bus_byteenable}, 32'h0);
      end
      if (!reset && (bus_read | bus_write | cpu_clk_enable))
         act++;
      if (reset) begin
         last_pulse = ncyc;
      end else if (cpu_clk_enable) begin
         check("step_pending", {31'h0, step_q.size() != 0}, 32'h1);
         if (step_q.size() != 0) begin
            s = step_q.pop_front();
            check("instr_rd", instr_readdata, s.i);
            check("data_rd", data_readdata, s.d);
            check("step_lat", 32'(ncyc - last_pulse), 32'(s.lat));
         end
         last_pulse = ncyc;
      end
      if (reset) begin
         last_nr = ncyc;
      end else if (nr_clk_enable) begin
         check("nr_lat", 32'(ncyc - last_nr), 32'd3);
         check("nr_instr", nr_instr, 32'h24020005);
         last_nr = ncyc;
      end
   end

   task automatic expect_step(input logic fetch, input logic [31:0] ia,
                              input logic dr, input logic dw,
                              input logic [31:0] da, input logic [31:0] wd,
                              input int lat, input logic [31:0] ei,
                              input logic [31:0] ed);
      if (fetch)
         bus_q.push_back('{a: {ia[31:2], 2'b00}, rw: 2'b10, wd: 32'h0});
      if (dw)
         bus_q.push_back('{a: {da[31:2], 2'b00}, rw: 2'b01, wd: wd});
      else if (dr)
         bus_q.push_back('{a: {da[31:2], 2'b00}, rw: 2'b10, wd: 32'h0});
      step_q.push_back('{i: ei, d: ed, lat: lat});
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (step_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      check("step_timeout", step_q.size(), 32'h0);
      #1;
   endtask

   task automatic step(input logic fetch, input logic [31:0] ia,
                       input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] wd,
                       input int ws, input int lat,
                       input logic [31:0] ei, input logic [31:0] ed);
      instr_address  = ia;
      data_read      = dr;
      data_write     = dw;
      data_address   = da;
      data_writedata = wd;
      ws_cfg         = ws;
      expect_step(fetch, ia, dr, dw, da, wd, lat, ei, ed);
      drain(40);
   endtask

   initial begin
      int n;
      mem[30'h2FF00000] = 32'h24020005;
      mem[30'h2FF00001] = 32'h8C430004;
      mem[30'h00000401] = 32'hCAFEF00D;
      reset = 1'b1;
      cpu_active = 1'b1;
      instr_address = 32'hBFC00000;
      data_address = 32'h0;
      data_read = 1'b0;
      data_write = 1'b0;
      data_writedata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_en", {31'h0, cpu_clk_enable}, 32'h0);
      check("rst_rd", {31'h0, bus_read}, 32'h0);
      check("rst_wr", {31'h0, bus_write}, 32'h0);
      check("rst_addr", bus_address, 32'h0);
      check("rst_wdata", bus_writedata, 32'h0);
      check("rst_instr", instr_readdata, 32'h0);
      check("rst_data", data_readdata, 32'h0);

      expect_step(1'b1, 32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0,
                  3, 32'h24020005, 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      drain(40);

      step(1'b0, 32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0, 0, 2,
           32'h24020005, 32'h0);
      step(1'b0, 32'hBFC00000, 1'b1, 1'b0, 32'h00001006, 32'h0, 3, 6,
           32'h24020005, 32'hCAFEF00D);
      step(1'b0, 32'hBFC00000, 1'b0, 1'b1, 32'hBFC00000, 32'hDEADBEEF,
           0, 3, 32'h24020005, 32'hCAFEF00D);
      step(1'b1, 32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0, 0, 3,
           32'hDEADBEEF, 32'hCAFEF00D);
      step(1'b0, 32'hBFC00000, 1'b1, 1'b1, 32'h00002000, 32'h12345678,
           0, 3, 32'hDEADBEEF, 32'hCAFEF00D);
      step(1'b0, 32'hBFC00000, 1'b1, 1'b0, 32'h00002000, 32'h0, 0, 3,
           32'hDEADBEEF, 32'h12345678);
      step(1'b1, 32'hBFC00004, 1'b1, 1'b0, 32'h00001004, 32'h0, 1, 6,
           32'h8C430004, 32'hCAFEF00D);

      // Abandon a stalled fetch with reset.
      instr_address = 32'hBFC00008;
      data_read = 1'b0;
      ws_cfg = 10;
      n = 0;
      while (!bus_read && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("ifetch_seen", {31'h0, bus_read}, 32'h1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      cpu_active = 1'b0;
      @(negedge clk);
      check("mid_rst_rd", {31'h0, bus_read}, 32'h0);
      check("mid_rst_wr", {31'h0, bus_write}, 32'h0);
      check("mid_rst_en", {31'h0, cpu_clk_enable}, 32'h0);
      ws_cfg = 0;
      @(posedge clk);
      #1 reset = 1'b0;
      act = 0;
      repeat (20) @(negedge clk);
      check("halt_act", act, 32'h0);
      check("bus_q_left", bus_q.size(), 32'h0);
      check("step_q_left", step_q.size(), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
